// File: rtl/sobel_3x3_linebuf.sv
// sobel_3x3_linebuf: streaming 3x3 Sobel edge filter over two line buffers.
// Two-stage pipeline: window/counters, then gradient arithmetic and output register.
module sobel_3x3_linebuf #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 320,
   parameter int CW     = $clog2(IMG_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sof,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] threshold,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);
   localparam int GW = DATA_W + 3;
   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
   state_t state;
   logic [CW-1:0] col, row, ec, er, nc, nr;
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] win [3][3];
   logic take, v1, m1;
   logic signed [GW-1:0] gx, gy;
   logic [GW-1:0] ax, ay, mag;
   logic [DATA_W-1:0] res;

   function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] x);
      return $signed({3'b000, x});
   endfunction

   function automatic logic [DATA_W-1:0] sat(input logic [GW-1:0] x);
      return (x > GW'({DATA_W{1'b1}})) ? '1 : x[DATA_W-1:0];
   endfunction

   // an sof pixel is accepted in any state and relocated to the frame origin
   assign take = in_valid && (sof || state != IDLE);
   assign ec = sof ? '0 : col;
   assign er = sof ? '0 : row;
   assign nc = (ec == CW'(IMG_W - 1)) ? '0 : ec + CW'(1);
   assign nr = (nc != '0) ? er : (&er ? er : er + CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         col <= '0;
         row <= '0;
         v1 <= 1'b0;
         m1 <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else begin
         v1 <= take;
         if (take) begin
            state <= (nr >= CW'(2)) ? RUN : FILL;
            col <= nc;
            row <= nr;
            m1 <= (er < CW'(2)) || (ec < CW'(2));
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[ec];
            win[1][2] <= lb0[ec];
            win[2][2] <= in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         lb1[ec] <= lb0[ec];
         lb0[ec] <= in_data;
      end
   end

   always_comb begin
      gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
      gy = (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]))
         - (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]));
      ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
      mag = ax + ay;
      res = m1 ? '0 :
            mode == 2'd0 ? sat(mag) :
            mode == 2'd1 ? {DATA_W{mag >= GW'(threshold)}} :
            mode == 2'd2 ? sat(ax) : sat(ay);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data <= '0;
      end else begin
         out_valid <= v1;
         if (v1) out_data <= res;
      end
   end
endmodule

// File: tb/tb_sobel_3x3_linebuf.sv
// tb_sobel_3x3_linebuf: directed and random frames against a frame-array Sobel model.
module tb_sobel_3x3_linebuf;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b1, sof = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = '0, threshold = '0;
   logic [1:0] mode = '0;
   logic out_valid;
   logic [7:0] out_data;
   int nchk = 0, nerr = 0, nout = 0;
   int exp_q[$];
   int img[8][8];
   bit mact = 0;
   int mr = 0, mc = 0;

   always #5 clk = ~clk;

   sobel_3x3_linebuf #(.DATA_W(8), .IMG_W(W)) dut (
      .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_data(in_data),
      .mode(mode), .threshold(threshold), .out_valid(out_valid), .out_data(out_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int x);
      return x > 255 ? 255 : x;
   endfunction

   function automatic int ref_px(input int r, input int c);
      int gx, gy, ax, ay;
      if (r < 2 || c < 2) return 0;
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]) - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
      ax = gx < 0 ? -gx : gx;
      ay = gy < 0 ? -gy : gy;
      case (mode)
         2'd0: return sat(ax + ay);
         2'd1: return (ax + ay) >= int'(threshold) ? 255 : 0;
         2'd2: return sat(ax);
         default: return sat(ay);
      endcase
   endfunction

   function automatic int pat(input int k, input int r, input int c);
      case (k)
         0: return 100;
         1: return c < 4 ? 0 : 200;
         2: return r < 3 ? 0 : 10;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   always @(negedge clk) begin
      if (out_valid) begin
         nout++;
         if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
         else chk("pixel", 32'(out_data), exp_q.pop_front());
      end
   end

   task automatic send(input bit s, input int p);
      sof = s;
      in_valid = 1'b1;
      in_data = p[7:0];
      if (s) begin
         mact = 1;
         mr = 0;
         mc = 0;
      end
      if (mact) begin
         img[mr][mc] = p;
         exp_q.push_back(ref_px(mr, mc));
         mc++;
         if (mc == W) begin
            mc = 0;
            if (mr < 7) mr++;
         end
      end
      @(posedge clk);
      #1;
      sof = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic frame(input int k, input int rows, input bit gaps);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < W; c++) begin
            send(r == 0 && c == 0, pat(k, r, c));
            if (gaps && $urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      rst = 1'b0;
      nout = 0;
      frame(0, 6, 0);
      drain();
      chk("flat_pulses", nout, 48);
      frame(1, 6, 1);
      drain();
      mode = 2'd1;
      threshold = 8'd255;
      frame(1, 6, 0);
      drain();
      threshold = 8'd0;
      frame(1, 6, 1);
      drain();
      mode = 2'd2;
      frame(2, 6, 0);
      drain();
      mode = 2'd3;
      frame(2, 6, 1);
      drain();
      mode = 2'd0;
      for (int i = 0; i <= 3 * W + 5; i++) send(i == 0, pat(3, i / W, i % W));
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_data", 32'(out_data), 0);
      exp_q.delete();
      mact = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) send(0, pat(3, 0, 0));
      drain();
      nout = 0;
      frame(0, 6, 1);
      drain();
      chk("post_rst_pulses", nout, 48);
      for (int i = 0; i < 2 * W + 3; i++) send(i == 0, pat(3, i / W, i % W));
      frame(3, 4, 1);
      drain();
      repeat (6) begin
         mode = 2'($urandom_range(0, 3));
         threshold = 8'($urandom_range(0, 255));
         frame(3, int'($urandom_range(3, 7)), 1);
         drain();
      end
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/sobel_3x3_linebuf.md
SOBEL_3X3_LINEBUF -- requirements
Module: sobel_3x3_linebuf

Interface
REQ-001 SHALL expose parameter DATA_W, default 8, meaning pixel bit width (4..12).
REQ-002 SHALL expose parameter IMG_W, default 320, meaning pixels per line and line-buffer depth (4..1024).
REQ-003 SHALL expose parameter CW, default $clog2(IMG_W), meaning column/row counter width.
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sof  input  1  start-of-frame pulse, sampled when in_valid=1.
REQ-007 SHALL have port in_valid  input  1  qualifies in_data; one pixel accepted per cycle when high.
REQ-008 SHALL have port in_data  input  DATA_W  grayscale pixel, raster order.
REQ-009 SHALL have port mode  input  2  output select: 0 mag, 1 binary, 2 |Gx|, 3 |Gy|.
REQ-010 SHALL have port threshold  input  DATA_W  binary-mode threshold.
REQ-011 SHALL have port out_valid  output  1  qualifies out_data.
REQ-012 SHALL have port out_data  output  DATA_W  filtered pixel.

Function
REQ-013 SHALL hold two IMG_W x DATA_W line buffers (previous two rows), read and written at the column index of each accepted pixel.
REQ-014 SHALL hold a 3x3 window register; each accepted pixel shifts the window left by one column, loading the new column {linebuf1[col], linebuf0[col], in_data} (top to bottom).
REQ-015 SHALL keep column counter col (0..IMG_W-1, wraps to 0 and increments row) and row counter row (saturating at 2^CW-1).
REQ-016 SHALL implement states IDLE -> FILL -> RUN: IDLE until an accepted pixel with sof=1; FILL while row<2; RUN once row>=2.
REQ-017 SHALL, on an accepted pixel with sof=1 in any state, treat that pixel as col=0,row=0 and restart FILL; line-buffer contents are not cleared.
REQ-018 SHALL ignore accepted pixels in IDLE (no buffer writes, no out_valid).
REQ-019 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p00+2p01+p02)-(p20+2p21+p22) at signed width DATA_W+3 with no intermediate overflow.
REQ-020 SHALL compute mag=|Gx|+|Gy| at width DATA_W+3; sat(x)=min(x, 2^DATA_W-1).
REQ-021 SHALL drive out_data per mode: 0 sat(mag); 1 all-ones if mag>=threshold else 0; 2 sat(|Gx|); 3 sat(|Gy|).
REQ-022 SHALL produce exactly one out_valid pulse per accepted pixel in FILL/RUN, two cycles after acceptance (stage 1 window/counters, stage 2 arithmetic/output register).
REQ-023 SHALL force out_data=0 (with out_valid=1) when the accepted pixel had row<2 or col<2 (window not fully inside frame).
REQ-024 SHALL sample mode and threshold in the same cycle as the Gx/Gy stage; changes take effect on the next output.
REQ-025 SHALL stall all pipeline state when in_valid=0 except output register, which drops out_valid to 0 with out_data held.
REQ-026 SHALL support back-to-back in_valid without bubbles (throughput 1 pixel/clk).

Reset
REQ-027 SHALL, on rst=1, asynchronously set state=IDLE, col=0, row=0, window=0, pipeline valids=0, out_valid=0, out_data=0.
REQ-028 SHALL not require line-buffer contents to be reset; their values are never output before being overwritten in the current frame, except across an sof restart per REQ-017 (rows 0-1 masked by REQ-023).
REQ-029 SHALL, on rst asserted mid-frame, discard in-flight pixels and emit no out_valid until after the next sof.

Verification
REQ-030 SHALL pass: IMG_W=8, sof then 8x6 frame of constant 100, mode 0 -> 48 out_valid pulses, every out_data=0.
REQ-031 SHALL pass: IMG_W=8, columns 0-3=0, 4-7=200, mode 0 -> at row>=2, col 4 and col 5 give sat(800)=255, other positions 0.
REQ-032 SHALL pass: same frame, mode 1, threshold 255 -> 255 at cols 4,5 (rows>=2), else 0; threshold 0 -> 255 at every row>=2,col>=2 position.
REQ-033 SHALL pass: horizontal step (rows 0-2=0, rows 3-5=10), mode 2 -> all 0; mode 3 -> 40 at rows 3,4 (col>=2), else 0.
REQ-034 SHALL pass: rst pulsed at row 3 col 5 -> out_valid=0 within 0 cycles (async), stays 0 through 10 further pixels without sof; new sof frame then matches REQ-030.
REQ-035 SHALL pass: sof reasserted at row 2 col 3 -> that pixel's output is 0, next two rows fully masked per REQ-023.
